// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter: ALU / load-return writeback arbiter, pending-load scoreboard
// Revision: 1.0
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [4:0]              alu_rd,
  input  logic [31:0]             alu_data,
  output logic                    alu_ready,
  input  logic                    mem_valid,
  input  logic [4:0]              mem_rd,
  input  logic [31:0]             mem_data,
  output logic                    mem_ready,
  input  logic [4:0]              q_a,
  input  logic [4:0]              q_b,
  output logic                    pend_a,
  output logic                    pend_b,
  output logic                    load,
  output logic [4:0]              dest,
  output logic [31:0]             in,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          load_q, load_d;
  logic [4:0]    dest_q, dest_d;
  logic [31:0]   in_q, in_d;

  logic w_nonempty;
  logic w_forced;
  logic w_alu_grant;
  logic w_pop;
  logic w_push;

  assign w_nonempty  = (count_q != '0);
  assign w_forced    = w_nonempty && (starve_q == LIMIT_C);
  assign alu_ready   = !w_forced;
  // Full-ness is judged on current occupancy, so a pop never frees a slot same-cycle.
  assign mem_ready   = (count_q < DEPTH_C);
  assign w_alu_grant = alu_valid && alu_ready;
  // count_q excludes this cycle's push, so a fresh entry cannot be popped yet.
  assign w_pop       = !w_alu_grant && w_nonempty;
  assign w_push      = mem_valid && mem_ready && (mem_rd != 5'd0);

  assign load  = load_q;
  assign dest  = dest_q;
  assign in    = in_q;
  assign count = count_q;

  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (q_a != 5'd0) && (rd_q[i] == q_a)) pend_a = 1'b1;
      if (vld_q[i] && (q_b != 5'd0) && (rd_q[i] == q_b)) pend_b = 1'b1;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(w_push) - CW'(w_pop);
    if (w_pop)  head_d = head_q + 1'b1;
    if (w_push) tail_d = tail_q + 1'b1;
  end

  always_comb begin
    starve_d = starve_q;
    if (!w_nonempty || w_pop) begin
      starve_d = '0;
    end else if (w_alu_grant && (starve_q != LIMIT_C)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    load_d = 1'b0;
    dest_d = dest_q;
    in_d   = in_q;
    if (w_alu_grant) begin
      // An x0 ALU result consumes the grant but writes nothing.
      if (alu_rd != 5'd0) begin
        load_d = 1'b1;
        dest_d = alu_rd;
        in_d   = alu_data;
      end
    end else if (w_pop) begin
      load_d = 1'b1;
      dest_d = rd_q[head_q];
      in_d   = data_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      load_q   <= 1'b0;
      dest_q   <= '0;
      in_q     <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      load_q   <= load_d;
      dest_q   <= dest_d;
      in_q     <= in_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      if (w_pop) vld_q[head_q] <= 1'b0;
      if (w_push) vld_q[tail_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      rd_q[tail_q]   <= mem_rd;
      data_q[tail_q] <= mem_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_arbiter: scoreboard bench with queue-based reference model
// Revision: 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  q_a;
  logic [4:0]  q_b;
  logic        pend_a;
  logic        pend_b;
  logic        load;
  logic [4:0]  dest;
  logic [31:0] in;
  logic [2:0]  count;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .q_a(q_a), .q_b(q_b), .pend_a(pend_a), .pend_b(pend_b),
    .load(load), .dest(dest), .in(in), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned cyc; logic [4:0] rd; logic [31:0] data; } wr_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

  wr_t         sb[$];
  ent_t        mq[$];
  int          starve = 0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [4:0]  last_dest = '0;
  logic [31:0] last_in = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consumes expected writes whenever the DUT presents one.
  initial begin
    wr_t w;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rst_load", {31'd0, load}, 32'd0);
        chk("rst_dest", {27'd0, dest}, 32'd0);
        chk("rst_in", in, 32'd0);
        last_dest = '0;
        last_in   = '0;
      end else if (load === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_load", {31'd0, load}, 32'd0);
        end else begin
          w = sb.pop_front();
          chk("wr_cycle", cyc, w.cyc);
          chk("wr_dest", {27'd0, dest}, {27'd0, w.rd});
          chk("wr_in", in, w.data);
          last_dest = w.rd;
          last_in   = w.data;
        end
      end else begin
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
          chk("missing_write", {31'd0, load}, 32'd1);
          void'(sb.pop_front());
        end
        chk("hold_dest", {27'd0, dest}, {27'd0, last_dest});
        chk("hold_in", in, last_in);
      end
    end
  end

  // Drive one cycle, check state-derived outputs, then advance the reference model.
  task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      input logic [4:0] qa, input logic [4:0] qb, output bit acc);
    bit exp_mr, exp_forced, awin, pop, push, pa, pb;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md; q_a = qa; q_b = qb;
    #1;
    exp_mr     = (mq.size() < DEPTH);
    exp_forced = (mq.size() != 0) && (starve == LIMIT);
    pa = 0; pb = 0;
    foreach (mq[i]) begin
      if (qa != 0 && mq[i].rd == qa) pa = 1;
      if (qb != 0 && mq[i].rd == qb) pb = 1;
    end
    chk("count", {29'd0, count}, mq.size());
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, exp_mr});
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, !exp_forced});
    chk("pend_a", {31'd0, pend_a}, {31'd0, pa});
    chk("pend_b", {31'd0, pend_b}, {31'd0, pb});
    acc = mv && exp_mr && !r;
    if (r) begin
      mq.delete();
      sb.delete();
      starve = 0;
      return;
    end
    awin = av && !exp_forced;
    pop  = !awin && (mq.size() != 0);
    push = mv && exp_mr && (mrd != 0);
    if (awin && ard != 0) sb.push_back('{cyc + 1, ard, ad});
    else if (pop) sb.push_back('{cyc + 1, mq[0].rd, mq[0].data});
    if (mq.size() == 0 || pop) starve = 0;
    else if (awin && starve < LIMIT) starve++;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{mrd, md});
  endtask

  task automatic idle(input logic [4:0] qa, input logic [4:0] qb);
    bit acc;
    step(0, 0, 0, 0, 0, 0, 0, qa, qb, acc);
  endtask

  initial begin
    bit acc;
    int k;
    rst = 1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0; q_a = 0; q_b = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    idle(0, 0);

    // Single load with pend query
    step(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0, acc);
    idle(5, 5);
    repeat (3) idle(5, 0);

    // Fill while ALU streams rd=1
    k = 0;
    for (int i = 0; i < 14; i++) begin
      step(0, 1, 1, 32'hA000_0000 + i, k < 5, 5'(10 + k), 32'h1000 + k, 10, 14, acc);
      if (acc && k < 5) k++;
    end
    repeat (8) idle(10, 14);

    // x0 filtering
    step(0, 1, 0, 32'h5555_5555, 1, 0, 32'h6666_6666, 0, 0, acc);
    repeat (2) idle(0, 0);

    // Order and wrap
    for (int i = 1; i <= 6; i++) step(0, 0, 0, 0, 1, 5'(i), 32'h111 * i, 3, 6, acc);
    repeat (8) idle(1, 6);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) step(0, 1, 7, 32'hC0DE_0000 + i, 1, 5'(20 + i), 32'hBEEF_0000 + i, 20, 21, acc);
    step(1, 1, 7, 32'hC0DE_00FF, 1, 22, 32'h0, 20, 21, acc);
    idle(20, 21);
    idle(20, 21);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(63) == 0, 1'($urandom_range(1)), 5'($urandom_range(7)), $urandom,
           1'($urandom_range(2) != 0), 5'($urandom_range(7)), $urandom,
           5'($urandom_range(7)), 5'($urandom_range(7)), acc);
    end

    repeat (20) idle(0, 0);
    chk("drain_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4; load-return queue entries, power of two, at least 2.
REQ-002 Parameter STARVE_LIMIT, default 4; number of consecutive ALU grants allowed while the queue is non-empty.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 alu_valid  input  1  ALU writeback request.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result.
REQ-008 alu_ready  output  1  ALU request is accepted this cycle.
REQ-009 mem_valid  input  1  load-unit writeback request.
REQ-010 mem_rd  input  5  load destination register.
REQ-011 mem_data  input  32  load data.
REQ-012 mem_ready  output  1  load request is accepted this cycle.
REQ-013 q_a, q_b  input  5 each  decode-stage source register queries.
REQ-014 pend_a, pend_b  output  1 each  the queried register has a queued, unwritten load.
REQ-015 load  output  1  register file write enable.
REQ-016 dest  output  5  register file write index.
REQ-017 in  output  32  register file write data.
REQ-018 count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-019 The block SHALL accept a load request only when mem_valid=1 and mem_ready=1; mem_ready SHALL be (count<DEPTH), based on current occupancy only, so there is no push-on-pop when the queue is full.
REQ-020 An accepted load with mem_rd=0 SHALL be discarded and SHALL NOT be enqueued.
REQ-021 An accepted load with mem_rd!=0 SHALL be enqueued at the tail in FIFO order; the head pointer and tail pointer SHALL wrap modulo DEPTH.
REQ-022 forced SHALL be (count!=0 && starve_cnt==STARVE_LIMIT); alu_ready SHALL be !forced.
REQ-023 Grant per cycle: if alu_valid && alu_ready, the ALU wins; otherwise, if count!=0, the queue head is popped; otherwise there is no grant.
REQ-024 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on an ALU grant while count!=0, and SHALL clear to 0 on any pop or whenever count=0.
REQ-025 Write outputs SHALL be registered with 1-cycle latency: the cycle after a grant, load=1 and dest/in carry the granted rd/data.
REQ-026 An ALU grant with alu_rd=0 SHALL produce load=0 the next cycle; it still counts as an ALU grant for REQ-024.
REQ-027 When no write is granted, the next cycle SHALL have load=0, and dest/in SHALL hold their previous values.
REQ-028 An entry pushed in cycle N SHALL NOT be popped before cycle N+1, so its earliest register file write is at cycle N+2; there is no push-to-pop bypass.
REQ-029 Simultaneous push and pop with count<DEPTH SHALL leave count unchanged and preserve order.
REQ-030 pend_a SHALL be 1 iff q_a!=0 and any valid queue entry has rd==q_a; pend_b SHALL be defined likewise; both are combinational from current state.
REQ-031 The registered write stage SHALL NOT assert pend_x, because the register file bypasses an in-flight write to its readers.
REQ-032 Ordering between ALU and load writes to the same rd is the issuer's responsibility; the block SHALL perform no WAW squashing.

Reset
REQ-033 While rst=1 at a clock edge: load=0, dest=0, in=0, count=0, head/tail=0, starve_cnt=0, and all queue entries invalid.
REQ-034 In the cycle after reset: mem_ready=1, alu_ready=1, pend_a=pend_b=0.
REQ-035 Reset asserted mid-operation SHALL drop all queued loads and any pending write; no write SHALL occur in the cycle following the reset edge.

Verification
REQ-036 Single load: mem_valid, rd=5, data=0xDEADBEEF at cycle 0 with ALU idle -> pend for q_a=5 is 1 in cycle 1; load=1, dest=5, in=0xDEADBEEF in cycle 2; count returns to 0.
REQ-037 Fill: 5 loads on back-to-back cycles while alu_valid=1 with rd=1 continuously -> mem_ready=0 after 4 accepts; the 5th load is held; the ALU wins 4 cycles, then alu_ready=0 for one cycle and the queue head writes.
REQ-038 x0 filtering: load rd=0 and ALU rd=0 each accepted -> count stays 0 and load never asserts.
REQ-039 Order and wrap: push rd 1..6 with ALU idle -> writes appear in order 1..6; pointers wrap past DEPTH; count never exceeds 4.
REQ-040 Reset mid-stream: queue count=3 and a write pending, assert rst for one cycle -> load=0 the next cycle, count=0, pend_a=pend_b=0, mem_ready=1.
